// File: rtl/epl_firdfail_seq_if.sv
// Read-path bundle for the FI-2 read-failure injector: raw read in, registered read out, injector controls.
// Default geometry macros apply only when the memory spec header has not already defined them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef WORD
`define WORD 16
`endif
`ifndef TWORD_WIDTH
`define TWORD_WIDTH 22
`endif
`ifndef FAULT
`define FAULT 4
`endif

interface epl_firdfail_seq_if #(parameter int CNT_WIDTH = 8);
    logic [`ADDR_WIDTH-1:0]  pA_i;
    logic                    pRDVLD_i;
    logic [`TWORD_WIDTH-1:0] pCODEWORD_i;
    logic [`FAULT-1:0]       pFS_i;
    logic [`WORD-1:0]        pFiWordMask_i;
    logic [`TWORD_WIDTH-1:0] pFiBitMask_i;
    logic                    pFiForceZero_i;
    logic                    pFiArm_i;
    logic [1:0]              pFiMode_i;
    logic [CNT_WIDTH-1:0]    pFiCnt_i;

    logic [`ADDR_WIDTH-1:0]  pA_o;
    logic                    pRDVLD_o;
    logic [`TWORD_WIDTH-1:0] pCODEWORD_o;
    logic [1:0]              pFiState_o;
    logic [CNT_WIDTH-1:0]    pInjCnt_o;
    logic                    pLogVld_o;
    logic [`ADDR_WIDTH-1:0]  pLogA_o;
    logic [`TWORD_WIDTH-1:0] pLogSyn_o;

    modport master (
        output pA_i, pRDVLD_i, pCODEWORD_i, pFS_i, pFiWordMask_i, pFiBitMask_i,
               pFiForceZero_i, pFiArm_i, pFiMode_i, pFiCnt_i,
        input  pA_o, pRDVLD_o, pCODEWORD_o, pFiState_o, pInjCnt_o, pLogVld_o, pLogA_o, pLogSyn_o
    );

    modport slave (
        input  pA_i, pRDVLD_i, pCODEWORD_i, pFS_i, pFiWordMask_i, pFiBitMask_i,
               pFiForceZero_i, pFiArm_i, pFiMode_i, pFiCnt_i,
        output pA_o, pRDVLD_o, pCODEWORD_o, pFiState_o, pInjCnt_o, pLogVld_o, pLogA_o, pLogSyn_o
    );
endinterface

// File: rtl/epl_firdfail_seq.sv
// FI-2 read-failure injector: 1-cycle read register that corrupts armed hits (persist/one-shot/burst/interval).
// Define EPL_FI_RD_LOG_EN to build the sticky first-injection log; otherwise the log outputs read 0.
//
// state | meaning
// IDLE  | FI-2 disabled or never armed; data passes unmodified
// ARMED | hits are evaluated against the latched mode/N
// DONE  | one-shot or burst finished; data passes unmodified until re-arm
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef WORD
`define WORD 16
`endif
`ifndef TWORD_WIDTH
`define TWORD_WIDTH 22
`endif
`ifndef FAULT
`define FAULT 4
`endif

module epl_firdfail_seq #(
    parameter int CNT_WIDTH = 8
) (
    input logic                pCLK_i,
    input logic                pRST_i,
    epl_firdfail_seq_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t                  state, stateNext;
    logic [1:0]              modeLat, modeNext;
    logic [CNT_WIDTH-1:0]    nLat, nNext;
    logic [CNT_WIDTH-1:0]    seqCnt, seqCntNext;
    logic [CNT_WIDTH-1:0]    injCnt, injCntNext;
    logic                    fsEn, hit, inj, seqTc;
    logic [`TWORD_WIDTH-1:0] corrupted;

    logic [`ADDR_WIDTH-1:0]  aReg;
    logic                    vldReg;
    logic [`TWORD_WIDTH-1:0] cwReg;

    always_comb begin
        stateNext  = state;
        modeNext   = modeLat;
        nNext      = nLat;
        seqCntNext = seqCnt;
        injCntNext = injCnt;
        inj        = 1'b0;
        fsEn       = bus.pFS_i[1];
        seqTc      = (seqCnt == CNT_ONE);
        hit        = bus.pRDVLD_i & fsEn & bus.pFiWordMask_i[bus.pA_i]
                     & (state == ST_ARMED) & ~bus.pFiArm_i;
        corrupted  = bus.pFiForceZero_i ? '0 : (bus.pCODEWORD_i ^ bus.pFiBitMask_i);

        if (!fsEn) begin
            stateNext = ST_IDLE;
        end else if (bus.pFiArm_i) begin
            stateNext  = ST_ARMED;
            modeNext   = bus.pFiMode_i;
            nNext      = (bus.pFiCnt_i == '0) ? CNT_ONE : bus.pFiCnt_i;
            seqCntNext = nNext;
            injCntNext = '0;
        end else if (hit) begin
            // seqCnt is a down-counter: remaining burst injections, or hits left to the next interval strike
            unique case (modeLat)
                2'b00: inj = 1'b1;
                2'b01: begin
                    inj       = 1'b1;
                    stateNext = ST_DONE;
                end
                2'b10: begin
                    inj = 1'b1;
                    if (seqTc) stateNext  = ST_DONE;
                    else       seqCntNext = seqCnt - CNT_ONE;
                end
                default: begin
                    inj        = seqTc;
                    seqCntNext = seqTc ? nLat : (seqCnt - CNT_ONE);
                end
            endcase
            if (inj && (injCnt != '1)) injCntNext = injCnt + CNT_ONE;
        end
    end

    always_ff @(posedge pCLK_i or posedge pRST_i) begin
        if (pRST_i) begin
            state   <= ST_IDLE;
            modeLat <= 2'b00;
            nLat    <= CNT_ONE;
            seqCnt  <= '0;
            injCnt  <= '0;
            aReg    <= '0;
            vldReg  <= 1'b0;
            cwReg   <= '0;
        end else begin
            state   <= stateNext;
            modeLat <= modeNext;
            nLat    <= nNext;
            seqCnt  <= seqCntNext;
            injCnt  <= injCntNext;
            aReg    <= bus.pA_i;
            vldReg  <= bus.pRDVLD_i;
            cwReg   <= inj ? corrupted : bus.pCODEWORD_i;
        end
    end

    assign bus.pA_o        = aReg;
    assign bus.pRDVLD_o    = vldReg;
    assign bus.pCODEWORD_o = cwReg;
    assign bus.pFiState_o  = state;
    assign bus.pInjCnt_o   = injCnt;

`ifdef EPL_FI_RD_LOG_EN
    logic                    logVld;
    logic [`ADDR_WIDTH-1:0]  logA;
    logic [`TWORD_WIDTH-1:0] logSyn;

    // Log survives FI-2 disable; only a qualified arm clears it
    always_ff @(posedge pCLK_i or posedge pRST_i) begin
        if (pRST_i) begin
            logVld <= 1'b0;
            logA   <= '0;
            logSyn <= '0;
        end else if (fsEn && bus.pFiArm_i) begin
            logVld <= 1'b0;
            logA   <= '0;
            logSyn <= '0;
        end else if (inj && !logVld) begin
            logVld <= 1'b1;
            logA   <= bus.pA_i;
            logSyn <= bus.pCODEWORD_i ^ corrupted;
        end
    end

    assign bus.pLogVld_o = logVld;
    assign bus.pLogA_o   = logA;
    assign bus.pLogSyn_o = logSyn;
`else
    assign bus.pLogVld_o = 1'b0;
    assign bus.pLogA_o   = '0;
    assign bus.pLogSyn_o = '0;
`endif
endmodule

// File: tb/tb_epl_firdfail_seq.sv
// Directed bench for the FI-2 read-failure injector; expected values are hand-computed per scenario.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef WORD
`define WORD 16
`endif
`ifndef TWORD_WIDTH
`define TWORD_WIDTH 22
`endif
`ifndef FAULT
`define FAULT 4
`endif

module tb_epl_firdfail_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    epl_firdfail_seq_if #(.CNT_WIDTH(8)) bus ();

    epl_firdfail_seq #(.CNT_WIDTH(8)) dut (
        .pCLK_i (clk),
        .pRST_i (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pA_i           = '0;
        bus.pRDVLD_i       = 1'b0;
        bus.pCODEWORD_i    = '0;
        bus.pFS_i          = 4'b0010;
        bus.pFiWordMask_i  = '0;
        bus.pFiBitMask_i   = '0;
        bus.pFiForceZero_i = 1'b0;
        bus.pFiArm_i       = 1'b0;
        bus.pFiMode_i      = 2'b00;
        bus.pFiCnt_i       = '0;
    endtask

    task automatic arm(input logic [1:0] mode, input logic [7:0] n);
        bus.pRDVLD_i  = 1'b0;
        bus.pFiMode_i = mode;
        bus.pFiCnt_i  = n;
        bus.pFiArm_i  = 1'b1;
        tick();
        bus.pFiArm_i  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        total++; if (bus.pFiState_o !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", bus.pFiState_o); end
        total++; if (bus.pInjCnt_o !== 8'd0) begin bad++; $display("FAIL reset_injcnt got=%0d exp=0", bus.pInjCnt_o); end
        total++; if ({bus.pRDVLD_o, bus.pA_o, bus.pCODEWORD_o} !== '0) begin bad++; $display("FAIL reset_data got=%b/%h/%h exp=0", bus.pRDVLD_o, bus.pA_o, bus.pCODEWORD_o); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_one_shot();
        idle_inputs();
        bus.pFiWordMask_i = 16'h0008;
        bus.pFiBitMask_i  = 22'h000001;
        arm(2'b01, 8'd0);
        total++; if (bus.pFiState_o !== 2'b01) begin bad++; $display("FAIL oneshot_armed got=%b exp=01", bus.pFiState_o); end
        bus.pA_i = 4'd3; bus.pRDVLD_i = 1'b1; bus.pCODEWORD_i = 22'h0ABCDE;
        tick();
        total++; if (bus.pCODEWORD_o !== 22'h0ABCDF) begin bad++; $display("FAIL oneshot_first got=%h exp=0abcdf", bus.pCODEWORD_o); end
        total++; if (bus.pFiState_o !== 2'b10) begin bad++; $display("FAIL oneshot_done got=%b exp=10", bus.pFiState_o); end
        tick();
        total++; if (bus.pCODEWORD_o !== 22'h0ABCDE) begin bad++; $display("FAIL oneshot_second got=%h exp=0abcde", bus.pCODEWORD_o); end
        total++; if (bus.pInjCnt_o !== 8'd1) begin bad++; $display("FAIL oneshot_cnt got=%0d exp=1", bus.pInjCnt_o); end
`ifdef EPL_FI_RD_LOG_EN
        total++; if ({bus.pLogVld_o, bus.pLogA_o, bus.pLogSyn_o} !== {1'b1, 4'd3, 22'h000001}) begin bad++; $display("FAIL oneshot_log got=%b/%h/%h exp=1/3/000001", bus.pLogVld_o, bus.pLogA_o, bus.pLogSyn_o); end
`else
        total++; if ({bus.pLogVld_o, bus.pLogA_o, bus.pLogSyn_o} !== '0) begin bad++; $display("FAIL oneshot_log got=%b/%h/%h exp=0", bus.pLogVld_o, bus.pLogA_o, bus.pLogSyn_o); end
`endif
    endtask

    task automatic test_reset_mid_burst();
        idle_inputs();
        bus.pFiWordMask_i = 16'h0020;
        bus.pFiBitMask_i  = 22'h000010;
        arm(2'b10, 8'd4);
        bus.pA_i = 4'd5; bus.pRDVLD_i = 1'b1; bus.pCODEWORD_i = 22'h000001;
        tick();
        tick();
        total++; if (bus.pInjCnt_o !== 8'd2) begin bad++; $display("FAIL t1_pre_cnt got=%0d exp=2", bus.pInjCnt_o); end
        rst = 1'b1;
        #2;
        total++; if (bus.pFiState_o !== 2'b00) begin bad++; $display("FAIL t1_state got=%b exp=00", bus.pFiState_o); end
        total++; if (bus.pInjCnt_o !== 8'd0) begin bad++; $display("FAIL t1_cnt got=%0d exp=0", bus.pInjCnt_o); end
        total++; if ({bus.pRDVLD_o, bus.pA_o, bus.pCODEWORD_o, bus.pLogVld_o} !== '0) begin bad++; $display("FAIL t1_outs got=%b/%h/%h/%b exp=0", bus.pRDVLD_o, bus.pA_o, bus.pCODEWORD_o, bus.pLogVld_o); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_burst();
        logic [21:0] exp;
        idle_inputs();
        bus.pFiWordMask_i = 16'h0080;
        bus.pFiBitMask_i  = 22'h000100;
        arm(2'b10, 8'd2);
        bus.pA_i = 4'd7; bus.pRDVLD_i = 1'b1; bus.pCODEWORD_i = 22'h0000F0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = (i <= 2) ? 22'h0001F0 : 22'h0000F0;
            total++; if (bus.pCODEWORD_o !== exp) begin bad++; $display("FAIL burst_hit%0d got=%h exp=%h", i, bus.pCODEWORD_o, exp); end
        end
        total++; if (bus.pFiState_o !== 2'b10) begin bad++; $display("FAIL burst_done got=%b exp=10", bus.pFiState_o); end
        total++; if (bus.pInjCnt_o !== 8'd2) begin bad++; $display("FAIL burst_cnt got=%0d exp=2", bus.pInjCnt_o); end
    endtask

    task automatic test_interval();
        logic [21:0] exp;
        idle_inputs();
        bus.pFiWordMask_i = 16'h0020;
        bus.pFiBitMask_i  = 22'h000003;
        arm(2'b11, 8'd3);
        bus.pA_i = 4'd5; bus.pRDVLD_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            bus.pCODEWORD_i = 22'(i * 16);
            tick();
            exp = (i == 3 || i == 6) ? (22'(i * 16) ^ 22'h000003) : 22'(i * 16);
            total++; if (bus.pCODEWORD_o !== exp) begin bad++; $display("FAIL interval_hit%0d got=%h exp=%h", i, bus.pCODEWORD_o, exp); end
        end
        total++; if (bus.pInjCnt_o !== 8'd2) begin bad++; $display("FAIL interval_cnt got=%0d exp=2", bus.pInjCnt_o); end
        total++; if (bus.pFiState_o !== 2'b01) begin bad++; $display("FAIL interval_state got=%b exp=01", bus.pFiState_o); end
        arm(2'b11, 8'd0);
        bus.pRDVLD_i = 1'b1; bus.pCODEWORD_i = 22'h000040;
        tick();
        tick();
        total++; if (bus.pCODEWORD_o !== 22'h000043) begin bad++; $display("FAIL interval_n0 got=%h exp=000043", bus.pCODEWORD_o); end
        total++; if (bus.pInjCnt_o !== 8'd2) begin bad++; $display("FAIL interval_n0_cnt got=%0d exp=2", bus.pInjCnt_o); end
    endtask

    task automatic test_force_zero();
        idle_inputs();
        bus.pFiWordMask_i  = 16'h0008;
        bus.pFiForceZero_i = 1'b1;
        bus.pFiBitMask_i   = 22'h000001;
        arm(2'b00, 8'd0);
        bus.pA_i = 4'd2; bus.pRDVLD_i = 1'b1; bus.pCODEWORD_i = 22'h155555;
        tick();
        total++; if ({bus.pA_o, bus.pCODEWORD_o} !== {4'd2, 22'h155555}) begin bad++; $display("FAIL fz_unmasked got=%h/%h exp=2/155555", bus.pA_o, bus.pCODEWORD_o); end
        bus.pA_i = 4'd3;
        tick();
        total++; if ({bus.pRDVLD_o, bus.pA_o, bus.pCODEWORD_o} !== {1'b1, 4'd3, 22'h000000}) begin bad++; $display("FAIL fz_masked got=%b/%h/%h exp=1/3/000000", bus.pRDVLD_o, bus.pA_o, bus.pCODEWORD_o); end
        bus.pRDVLD_i = 1'b0; bus.pCODEWORD_i = 22'h0AAAAA;
        tick();
        total++; if ({bus.pRDVLD_o, bus.pCODEWORD_o} !== {1'b0, 22'h0AAAAA}) begin bad++; $display("FAIL fz_novalid got=%b/%h exp=0/0aaaaa", bus.pRDVLD_o, bus.pCODEWORD_o); end
        total++; if (bus.pInjCnt_o !== 8'd1) begin bad++; $display("FAIL fz_cnt got=%0d exp=1", bus.pInjCnt_o); end
    endtask

    task automatic test_arm_coincident();
        bus.pFiForceZero_i = 1'b0;
        bus.pFiBitMask_i   = 22'h000001;
        bus.pFiMode_i      = 2'b00;
        bus.pFiArm_i       = 1'b1;
        bus.pA_i = 4'd3; bus.pRDVLD_i = 1'b1; bus.pCODEWORD_i = 22'h000010;
        tick();
        total++; if (bus.pCODEWORD_o !== 22'h000010) begin bad++; $display("FAIL armhit_clean got=%h exp=000010", bus.pCODEWORD_o); end
        total++; if ({bus.pFiState_o, bus.pInjCnt_o} !== {2'b01, 8'd0}) begin bad++; $display("FAIL armhit_reset got=%b/%0d exp=01/0", bus.pFiState_o, bus.pInjCnt_o); end
        bus.pFiArm_i = 1'b0;
        tick();
        total++; if (bus.pCODEWORD_o !== 22'h000011) begin bad++; $display("FAIL armhit_next got=%h exp=000011", bus.pCODEWORD_o); end
        total++; if (bus.pInjCnt_o !== 8'd1) begin bad++; $display("FAIL armhit_cnt got=%0d exp=1", bus.pInjCnt_o); end
    endtask

    task automatic test_disable();
        bus.pFS_i = 4'b0000;
        bus.pCODEWORD_i = 22'h000020;
        tick();
        total++; if ({bus.pFiState_o, bus.pCODEWORD_o, bus.pInjCnt_o} !== {2'b00, 22'h000020, 8'd1}) begin bad++; $display("FAIL dis_first got=%b/%h/%0d exp=00/000020/1", bus.pFiState_o, bus.pCODEWORD_o, bus.pInjCnt_o); end
        bus.pFiArm_i = 1'b1;
        tick();
        total++; if ({bus.pFiState_o, bus.pInjCnt_o} !== {2'b00, 8'd1}) begin bad++; $display("FAIL dis_arm_ignored got=%b/%0d exp=00/1", bus.pFiState_o, bus.pInjCnt_o); end
`ifdef EPL_FI_RD_LOG_EN
        total++; if ({bus.pLogVld_o, bus.pLogA_o, bus.pLogSyn_o} !== {1'b1, 4'd3, 22'h000001}) begin bad++; $display("FAIL dis_log got=%b/%h/%h exp=1/3/000001", bus.pLogVld_o, bus.pLogA_o, bus.pLogSyn_o); end
`else
        total++; if ({bus.pLogVld_o, bus.pLogA_o, bus.pLogSyn_o} !== '0) begin bad++; $display("FAIL dis_log got=%b/%h/%h exp=0", bus.pLogVld_o, bus.pLogA_o, bus.pLogSyn_o); end
`endif
        bus.pFiArm_i = 1'b0;
        bus.pFS_i = 4'b0010;
        tick();
        tick();
        total++; if ({bus.pFiState_o, bus.pCODEWORD_o} !== {2'b00, 22'h000020}) begin bad++; $display("FAIL dis_reenable got=%b/%h exp=00/000020", bus.pFiState_o, bus.pCODEWORD_o); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_reset_mid_burst();
        test_burst();
        test_interval();
        test_force_zero();
        test_arm_coincident();
        test_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog bench exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
